// File: rtl/track_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : track_fetch
//  Purpose  : Per-frame multi-track sample fetcher. On each audio tick it
//             reads one word per channel from sample memory, gathers them in
//             shadow registers and publishes all lanes together with a
//             one-cycle frame_valid pulse. Handles looping, rewind and
//             overrun (tick while busy).
//  Revision : 1.0 - initial release
// ============================================================================
module track_fetch #(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 4,
  parameter int ADDR_W       = 17,
  parameter int READ_LATENCY = 2,
  localparam int CH_W        = $clog2(CHANNELS),
  localparam int POS_W       = ADDR_W - CH_W
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     sample_tick,
  input  logic                                     play,
  input  logic                                     rewind,
  input  logic [POS_W-1:0]                         loop_len,
  output logic [ADDR_W-1:0]                        mem_addr,
  input  logic signed [WIDTH-1:0]                  mem_data,
  output logic signed [CHANNELS-1:0][WIDTH-1:0]    data_dry,
  output logic                                     frame_valid,
  output logic [POS_W-1:0]                         position,
  output logic                                     busy,
  output logic                                     overrun
);

  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [ADDR_W-1:0]              r_addr;
  logic [CH_W-1:0]                r_ch;
  logic [WAIT_W-1:0]              r_wait;
  logic [POS_W-1:0]               r_pos;
  logic                           r_silent;
  logic                           r_pend;
  logic                           r_ovr;
  logic                           r_fv;
  logic [CHANNELS-1:0][WIDTH-1:0] r_dry;
  logic signed [WIDTH-1:0]        r_shadow [CHANNELS];
  logic [READ_LATENCY-1:0]        r_vpipe;
  logic [CH_W-1:0]                r_cap_ch;

  logic                           w_last_ch;
  logic                           w_wait_done;
  logic [CH_W-1:0]                w_ch_inc;
  logic [POS_W:0]                 w_pos_inc;
  logic [POS_W-1:0]               w_pos_adv;
  logic [POS_W-1:0]               w_start_pos;

  assign w_last_ch   = (r_ch == CH_W'(CHANNELS - 1));
  assign w_wait_done = (r_wait == WAIT_W'(READ_LATENCY - 1));
  assign w_ch_inc    = r_ch + CH_W'(1);
  // Compare one bit wider so position >= loop_len (including loop_len 0/1)
  // always wraps to 0 instead of running off the end of the loop.
  assign w_pos_inc   = {1'b0, r_pos} + (POS_W + 1)'(1);
  assign w_pos_adv   = (w_pos_inc >= {1'b0, loop_len}) ? '0 : w_pos_inc[POS_W-1:0];
  // A rewind coinciding with the tick wins: the frame fetches from position 0.
  assign w_start_pos = rewind ? '0 : r_pos;

  assign mem_addr    = r_addr;
  assign data_dry    = r_dry;
  assign frame_valid = r_fv;
  assign position    = r_pos;
  assign busy        = (r_state != S_IDLE);
  assign overrun     = r_ovr;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode: play is only looked at here, in IDLE on a tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (sample_tick) w_state_next = play ? S_ISSUE : S_COMMIT;
      S_ISSUE:  if (w_last_ch)   w_state_next = S_WAIT;
      S_WAIT:   if (w_wait_done) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Read-return tracking: a delayed copy of "address valid" marks the cycle
  // each requested word is on mem_data; words land in channel order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_vpipe  <= '0;
      r_cap_ch <= '0;
      for (int k = 0; k < CHANNELS; k++) r_shadow[k] <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) r_vpipe[i] <= r_vpipe[i-1];
      r_vpipe[0] <= (r_state == S_ISSUE);
      if (r_vpipe[READ_LATENCY-1]) begin
        r_shadow[r_cap_ch] <= mem_data;
        r_cap_ch           <= r_cap_ch + CH_W'(1);
      end
      if (r_state == S_IDLE && sample_tick) r_cap_ch <= '0;
    end
  end

  // Frame control: address issue, wait count, position, rewind and overrun.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_addr   <= '0;
      r_ch     <= '0;
      r_wait   <= '0;
      r_pos    <= '0;
      r_silent <= 1'b0;
      r_pend   <= 1'b0;
      r_ovr    <= 1'b0;
      r_fv     <= 1'b0;
      r_dry    <= '0;
    end else begin
      r_fv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rewind) begin
            r_pos <= '0;
            r_ovr <= 1'b0;
          end
          if (sample_tick) begin
            r_silent <= ~play;
            r_ch     <= '0;
            if (play) r_addr <= {w_start_pos, CH_W'(0)};
          end
        end
        S_ISSUE: begin
          if (!w_last_ch) begin
            r_ch   <= w_ch_inc;
            r_addr <= {r_pos, w_ch_inc};
          end else begin
            r_wait <= '0;
          end
        end
        S_WAIT: r_wait <= r_wait + WAIT_W'(1);
        S_COMMIT: begin
          r_fv <= 1'b1;
          for (int k = 0; k < CHANNELS; k++) r_dry[k] <= r_silent ? '0 : r_shadow[k];
          if (r_pend || rewind) begin
            r_pos <= '0;
            r_ovr <= 1'b0;
          end else if (!r_silent) begin
            r_pos <= w_pos_adv;
          end
        end
        default: ;
      endcase
      // Busy-time events: ticks are dropped (sticky overrun), rewinds wait
      // for the commit. A tick in COMMIT still counts as an overrun.
      if (r_state != S_IDLE) begin
        if (rewind && r_state != S_COMMIT) r_pend <= 1'b1;
        if (r_state == S_COMMIT)           r_pend <= 1'b0;
        if (sample_tick)                   r_ovr  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_track_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_track_fetch
//  Purpose  : Directed self-checking bench for track_fetch with a scoreboard
//             of expected frames and a latency-2 memory, word(a) = 3a - 100.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_track_fetch;

  localparam int WIDTH        = 16;
  localparam int CHANNELS     = 4;
  localparam int ADDR_W       = 17;
  localparam int READ_LATENCY = 2;
  localparam int CH_W         = 2;
  localparam int POS_W        = 15;
  // An output "at edge N" is the value presented to edge N (launched at edge
  // N-1); it is sampled here 1 time unit after edge N-1, so cycle index
  // c after the tick edge corresponds to edge c+1.
  localparam int LAT_PLAY     = CHANNELS + READ_LATENCY + 2 - 1;
  localparam int LAT_SILENT   = 2 - 1;

  logic                                  clk_in = 1'b0;
  logic                                  rst_in;
  logic                                  sample_tick;
  logic                                  play;
  logic                                  rewind;
  logic [POS_W-1:0]                      loop_len;
  logic [ADDR_W-1:0]                     mem_addr;
  logic signed [WIDTH-1:0]               mem_data;
  logic signed [WIDTH-1:0]               mem_p1;
  logic signed [CHANNELS-1:0][WIDTH-1:0] data_dry;
  logic                                  frame_valid;
  logic [POS_W-1:0]                      position;
  logic                                  busy;
  logic                                  overrun;

  typedef struct packed {
    logic [CHANNELS-1:0][WIDTH-1:0] lanes;
    logic [POS_W-1:0]               pos;
  } frame_t;

  frame_t            sb[$];
  frame_t            mon_f;
  int                checks = 0;
  int                errors = 0;
  int                m_pos  = 0;
  int                m_len  = 5;
  logic              m_ovr  = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  int                seq[5] = '{1, 2, 0, 1, 2};

  track_fetch #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_tick(sample_tick), .play(play),
    .rewind(rewind), .loop_len(loop_len), .mem_addr(mem_addr), .mem_data(mem_data),
    .data_dry(data_dry), .frame_valid(frame_valid), .position(position),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic signed [WIDTH-1:0] word(input int a);
    return WIDTH'(a * 3 - 100);
  endfunction

  function automatic int adv(input int p, input int len);
    return (p + 1 >= len) ? 0 : p + 1;
  endfunction

  // Two-stage memory pipeline: data for the address seen in cycle c is on
  // mem_data in cycle c+2.
  always @(posedge clk_in) begin
    mem_p1   <= word(int'(mem_addr));
    mem_data <= mem_p1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Scoreboard consumer: every frame_valid pops one expected frame.
  always @(posedge clk_in) begin
    #1;
    if (frame_valid === 1'b1) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_f = sb.pop_front();
        chk("data_dry", data_dry, mon_f.lanes);
        chk("commit_position", 64'(position), 64'(mon_f.pos));
      end
    end
  end

  // One frame: tick now, optional extra tick / rewind at a cycle index,
  // play inverted mid-frame to prove it is ignored.
  task automatic do_frame(input logic pl, input logic rew_at_tick, input int xtick_c,
                          input int rew_c, input int exp_lat);
    frame_t      f;
    int          start_pos;
    int          lat;
    int          nfv;
    logic [63:0] dry_before;
    start_pos = rew_at_tick ? 0 : m_pos;
    for (int k = 0; k < CHANNELS; k++)
      f.lanes[k] = pl ? word(start_pos * CHANNELS + k) : '0;
    if (rew_c >= 0) f.pos = '0;
    else if (pl)    f.pos = POS_W'(adv(start_pos, m_len));
    else            f.pos = POS_W'(start_pos);
    sb.push_back(f);
    dry_before  = data_dry;
    sample_tick = 1'b1;
    play        = pl;
    rewind      = rew_at_tick;
    step();
    sample_tick = 1'b0;
    rewind      = 1'b0;
    play        = ~pl;
    lat = -1;
    nfv = 0;
    for (int c = 0; c < 19; c++) begin
      if (pl && c < CHANNELS)
        chk("issue_addr", 64'(mem_addr), 64'(start_pos * CHANNELS + c));
      if (frame_valid === 1'b1) begin
        nfv++;
        if (lat < 0) lat = c;
      end else if (lat < 0) begin
        chk("dry_held", data_dry, dry_before);
      end
      sample_tick = (c == xtick_c);
      rewind      = (c == rew_c);
      step();
    end
    sample_tick = 1'b0;
    rewind      = 1'b0;
    play        = pl;
    chk("fv_latency", 64'(lat), 64'(exp_lat));
    chk("fv_count", 64'(nfv), 64'd1);
    if (!pl) chk("silent_addr_held", 64'(mem_addr), 64'(m_addr));
    else     m_addr = ADDR_W'(start_pos * CHANNELS + CHANNELS - 1);
    m_pos = int'(f.pos);
    if (xtick_c >= 0) m_ovr = 1'b1;
    if (rew_c >= 0 || rew_at_tick) m_ovr = 1'b0;
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("busy_idle", 64'(busy), 64'd0);
    chk("position_after", 64'(position), 64'(m_pos));
  endtask

  task automatic idle_rewind();
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    m_pos  = 0;
    m_ovr  = 1'b0;
    chk("rewind_pos", 64'(position), 64'd0);
    chk("rewind_ovr", 64'(overrun), 64'd0);
  endtask

  // Directed sequence.
  initial begin
    rst_in = 1'b1; sample_tick = 1'b0; play = 1'b0; rewind = 1'b0;
    loop_len = POS_W'(5); m_len = 5;
    repeat (3) step();
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_dry", data_dry, 64'd0);
    chk("rst_pos", 64'(position), 64'd0);
    chk("rst_fv", 64'(frame_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    rst_in = 1'b0;

    // Basic play frame from position 0.
    do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);
    chk("lane3", 64'($signed(data_dry[3])), 64'(-91));
    chk("lane2", 64'($signed(data_dry[2])), 64'(-94));
    chk("lane1", 64'($signed(data_dry[1])), 64'(-97));
    chk("lane0", 64'($signed(data_dry[0])), 64'(-100));
    chk("first_pos", 64'(position), 64'd1);

    // Loop of three frames.
    idle_rewind();
    loop_len = POS_W'(3); m_len = 3;
    for (int i = 0; i < 5; i++) begin
      do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);
      chk("wrap_seq", 64'(position), 64'(seq[i]));
    end

    // Silent frame.
    do_frame(1'b0, 1'b0, -1, -1, LAT_SILENT);

    // Dropped tick three cycles in, then an idle rewind.
    do_frame(1'b1, 1'b0, 2, -1, LAT_PLAY);
    idle_rewind();

    // Mid-frame rewind from position 2.
    loop_len = POS_W'(5); m_len = 5;
    do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);
    do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);
    do_frame(1'b1, 1'b0, -1, 3, LAT_PLAY);

    // Shrinking the loop below the position, then degenerate loop lengths.
    for (int i = 0; i < 3; i++) do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);
    loop_len = POS_W'(2); m_len = 2;
    do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);
    loop_len = POS_W'(1); m_len = 1;
    do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);
    loop_len = POS_W'(0); m_len = 0;
    do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);

    // Rewind coinciding with the tick, and a tick landing in COMMIT.
    loop_len = POS_W'(5); m_len = 5;
    do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);
    do_frame(1'b1, 1'b1, -1, -1, LAT_PLAY);
    do_frame(1'b1, 1'b0, LAT_PLAY - 1, -1, LAT_PLAY);
    idle_rewind();

    // Reset at edge 5 of a frame aborts it; the next cycle accepts a tick.
    do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);
    sample_tick = 1'b1;
    play        = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("abort_no_fv", 64'(frame_valid), 64'd0);
      step();
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    m_pos = 0; m_ovr = 1'b0; m_addr = '0;
    chk("abort_addr", 64'(mem_addr), 64'd0);
    chk("abort_dry", data_dry, 64'd0);
    chk("abort_pos", 64'(position), 64'd0);
    chk("abort_fv", 64'(frame_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ovr", 64'(overrun), 64'd0);
    do_frame(1'b1, 1'b0, -1, -1, LAT_PLAY);

    repeat (5) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
